// File: rtl/pcie_rx_fun.sv
// -----------------------------------------------------------------------------
// pcie_rx_fun
//
// Purpose:
//   Fetches video frames from four host frame buffers over a DMA read engine and
//   streams them out through a first-word-fall-through FIFO. One fixed-size read
//   request is outstanding at a time. A new request is issued only when the FIFO
//   has room for its whole completion. After RPF requests the frame is complete:
//   o_dma_rd_done pulses and fetching moves to the next buffer (0,1,2,3,0,...).
//
// Ports:
//   i_pcie_clk, i_pcie_rst            clock, asynchronous active-high reset
//   i_dma_base_addr .. _addr4         base addresses of host frame buffers 0-3
//   i_start_rx_flag                   level; high runs, low aborts to idle
//   i_dma_cmd_rdy / o_dma_req         request handshake
//   o_dma_addr / o_dma_len            request address, length in DW (constant)
//   i_dma_wr_data / i_dma_wr_en       completion data and strobe
//   i_dma_rx_done                     pulse, current request complete
//   o_video_data/_valid, i_video_ready  output stream (valid/ready)
//   o_video_sof / o_video_eof         first / last word of a frame
//   o_dma_rd_index / o_dma_rd_done    index of last fetched frame, 1-cycle pulse
//   o_overflow / o_len_err            sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module pcie_rx_fun #(
  parameter int DMA_ADDR_WIDTH  = 64,
  parameter int PCIE_DATA_WIDTH = 256,
  parameter int DMA_LEN         = 3840,
  parameter int FRAME_BYTES     = 4147200,
  parameter int FIFO_DEPTH      = 256
) (
  input  logic                       i_pcie_clk,
  input  logic                       i_pcie_rst,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_dma_base_addr,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_dma_base_addr2,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_dma_base_addr3,
  input  logic [DMA_ADDR_WIDTH-1:0]  i_dma_base_addr4,
  input  logic                       i_start_rx_flag,
  input  logic                       i_dma_cmd_rdy,
  output logic                       o_dma_req,
  output logic [DMA_ADDR_WIDTH-1:0]  o_dma_addr,
  output logic [9:0]                 o_dma_len,
  input  logic [PCIE_DATA_WIDTH-1:0] i_dma_wr_data,
  input  logic                       i_dma_wr_en,
  input  logic                       i_dma_rx_done,
  output logic [PCIE_DATA_WIDTH-1:0] o_video_data,
  output logic                       o_video_valid,
  input  logic                       i_video_ready,
  output logic                       o_video_sof,
  output logic                       o_video_eof,
  output logic [1:0]                 o_dma_rd_index,
  output logic                       o_dma_rd_done,
  output logic                       o_overflow,
  output logic                       o_len_err
);

  // Derived sizes
  localparam int WPR   = DMA_LEN * 8 / PCIE_DATA_WIDTH;   // words per request
  localparam int RPF   = FRAME_BYTES / DMA_LEN;           // requests per frame
  localparam int WPF   = RPF * WPR;                       // words per frame
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(WPR + 2);                 // room for WPR+1 so excess words are visible
  localparam int RC_W  = (RPF > 1) ? $clog2(RPF) : 1;
  localparam int OC_W  = (WPF > 1) ? $clog2(WPF) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_FRAME_END  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                      state_q;
  logic                        req_q;
  logic [DMA_ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]                  idx_q;
  logic [1:0]                  rd_index_q;
  logic                        rd_done_q;
  logic [RC_W-1:0]             req_cnt_q;
  logic [WC_W-1:0]             wc_q;
  logic                        len_err_q;

  logic [PCIE_DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic [OC_W-1:0]             out_cnt_q;
  logic [OC_W-1:0]             out_cnt_d;
  logic                        valid_q;
  logic                        sof_q;
  logic                        eof_q;
  logic                        overflow_q;

  logic                        full_s;
  logic                        pop_s;
  logic                        push_s;
  logic                        drop_s;
  logic [CNT_W-1:0]            free_s;
  logic                        space_ok_s;
  logic [WC_W-1:0]             wc_inc_s;
  logic [1:0]                  idx_nxt_s;
  logic [DMA_ADDR_WIDTH-1:0]   next_base_s;

  // ---------------------------------------------------------------------------
  // FIFO handshake terms. A write while full is still accepted when a pop
  // frees the slot in the same cycle, so full+simultaneous read/write is lossless.
  // ---------------------------------------------------------------------------
  assign full_s     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop_s      = valid_q & i_video_ready;
  assign push_s     = i_start_rx_flag & i_dma_wr_en & (~full_s | pop_s);
  assign drop_s     = i_start_rx_flag & i_dma_wr_en & full_s & ~pop_s;
  assign free_s     = CNT_W'(FIFO_DEPTH) - cnt_q;
  assign space_ok_s = (free_s >= CNT_W'(WPR));
  assign idx_nxt_s  = idx_q + 2'd1;

  // Next FIFO occupancy and output word position
  always_comb begin
    cnt_d     = cnt_q;
    out_cnt_d = out_cnt_q;
    if (!i_start_rx_flag) begin
      cnt_d     = '0;
      out_cnt_d = '0;
    end else begin
      if (push_s && !pop_s) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop_s && !push_s) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
      if (pop_s) begin
        if (out_cnt_q == OC_W'(WPF - 1)) begin
          out_cnt_d = '0;
        end else begin
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end else begin
        out_cnt_d = out_cnt_q;
      end
    end
  end

  // Words received for the current request; saturates so a runaway count never
  // wraps back onto WPR
  always_comb begin
    wc_inc_s = wc_q;
    if (i_dma_wr_en && (wc_q != {WC_W{1'b1}})) begin
      wc_inc_s = wc_q + 1'b1;
    end else begin
      wc_inc_s = wc_q;
    end
  end

  // Base address of the buffer that follows the current one
  always_comb begin
    next_base_s = i_dma_base_addr;
    case (idx_nxt_s)
      2'd0:    next_base_s = i_dma_base_addr;
      2'd1:    next_base_s = i_dma_base_addr2;
      2'd2:    next_base_s = i_dma_base_addr3;
      2'd3:    next_base_s = i_dma_base_addr4;
      default: next_base_s = i_dma_base_addr;
    endcase
  end

  // FIFO storage; no reset needed since reads are masked by valid
  always_ff @(posedge i_pcie_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_dma_wr_data;
    end
  end

  // FIFO pointers, occupancy, output framing and overflow flag
  always_ff @(posedge i_pcie_clk or posedge i_pcie_rst) begin
    if (i_pcie_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_cnt_q  <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (!i_start_rx_flag) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q     <= cnt_d;
      out_cnt_q <= out_cnt_d;
      // Flags are computed from next state so they line up with the head word
      valid_q   <= (cnt_d != '0);
      sof_q     <= (cnt_d != '0) && (out_cnt_d == '0);
      eof_q     <= (cnt_d != '0) && (out_cnt_d == OC_W'(WPF - 1));
      if (drop_s) overflow_q <= 1'b1;
    end
  end

  // Request sequencing FSM with registered request/frame outputs
  always_ff @(posedge i_pcie_clk or posedge i_pcie_rst) begin
    if (i_pcie_rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      idx_q      <= 2'd0;
      rd_index_q <= 2'd0;
      rd_done_q  <= 1'b0;
      req_cnt_q  <= '0;
      wc_q       <= '0;
      len_err_q  <= 1'b0;
    end else if (!i_start_rx_flag) begin
      // Abort: everything but the sticky flag returns to idle values
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      idx_q      <= 2'd0;
      rd_index_q <= 2'd0;
      rd_done_q  <= 1'b0;
      req_cnt_q  <= '0;
      wc_q       <= '0;
    end else begin
      rd_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          addr_q    <= i_dma_base_addr;
          idx_q     <= 2'd0;
          req_cnt_q <= '0;
          wc_q      <= '0;
          state_q   <= ST_WAIT_SPACE;
        end
        ST_WAIT_SPACE: begin
          if (space_ok_s) begin
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_dma_cmd_rdy) begin
            req_q   <= 1'b0;
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i_dma_rx_done) begin
            wc_q <= '0;
            // A word arriving together with done still belongs to this request
            if (wc_inc_s != WC_W'(WPR)) len_err_q <= 1'b1;
            if (req_cnt_q == RC_W'(RPF - 1)) begin
              rd_done_q  <= 1'b1;
              rd_index_q <= idx_q;
              state_q    <= ST_FRAME_END;
            end else begin
              req_cnt_q <= req_cnt_q + 1'b1;
              addr_q    <= addr_q + DMA_ADDR_WIDTH'(DMA_LEN);
              state_q   <= ST_WAIT_SPACE;
            end
          end else begin
            wc_q <= wc_inc_s;
          end
        end
        ST_FRAME_END: begin
          idx_q     <= idx_nxt_s;
          addr_q    <= next_base_s;
          req_cnt_q <= '0;
          state_q   <= ST_WAIT_SPACE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dma_req      = req_q;
  assign o_dma_addr     = addr_q;
  assign o_dma_len      = 10'(DMA_LEN / 4);
  assign o_video_data   = valid_q ? mem_q[rd_ptr_q] : '0;
  assign o_video_valid  = valid_q;
  assign o_video_sof    = sof_q;
  assign o_video_eof    = eof_q;
  assign o_dma_rd_index = rd_index_q;
  assign o_dma_rd_done  = rd_done_q;
  assign o_overflow     = overflow_q;
  assign o_len_err      = len_err_q;

endmodule

// File: tb/tb_pcie_rx_fun.sv
// -----------------------------------------------------------------------------
// tb_pcie_rx_fun
//
// Directed bench for pcie_rx_fun with a small configuration (2 words per
// request, 4 requests per frame, 8-entry FIFO). The initial block plays the DMA
// engine; a negedge monitor checks every popped word against a queue of sent
// words and checks sof/eof from its own position counter.
// -----------------------------------------------------------------------------
module tb_pcie_rx_fun;

  localparam int AW = 64;
  localparam int DW = 256;

  logic          clk;
  logic          i_pcie_rst;
  logic [AW-1:0] base0, base1, base2, base3;
  logic          i_start_rx_flag;
  logic          i_dma_cmd_rdy;
  logic          o_dma_req;
  logic [AW-1:0] o_dma_addr;
  logic [9:0]    o_dma_len;
  logic [DW-1:0] i_dma_wr_data;
  logic          i_dma_wr_en;
  logic          i_dma_rx_done;
  logic [DW-1:0] o_video_data;
  logic          o_video_valid;
  logic          i_video_ready;
  logic          o_video_sof;
  logic          o_video_eof;
  logic [1:0]    o_dma_rd_index;
  logic          o_dma_rd_done;
  logic          o_overflow;
  logic          o_len_err;

  int            checks   = 0;
  int            failures = 0;
  int            mon_idx  = 0;
  int            mon_pops = 0;
  logic [31:0]   data_ctr = 32'h1000_0001;
  bit            rand_mode = 1'b0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] mon_exp;

  pcie_rx_fun #(
    .DMA_ADDR_WIDTH (AW),
    .PCIE_DATA_WIDTH(DW),
    .DMA_LEN        (64),
    .FRAME_BYTES    (256),
    .FIFO_DEPTH     (8)
  ) dut (
    .i_pcie_clk      (clk),
    .i_pcie_rst      (i_pcie_rst),
    .i_dma_base_addr (base0),
    .i_dma_base_addr2(base1),
    .i_dma_base_addr3(base2),
    .i_dma_base_addr4(base3),
    .i_start_rx_flag (i_start_rx_flag),
    .i_dma_cmd_rdy   (i_dma_cmd_rdy),
    .o_dma_req       (o_dma_req),
    .o_dma_addr      (o_dma_addr),
    .o_dma_len       (o_dma_len),
    .i_dma_wr_data   (i_dma_wr_data),
    .i_dma_wr_en     (i_dma_wr_en),
    .i_dma_rx_done   (i_dma_rx_done),
    .o_video_data    (o_video_data),
    .o_video_valid   (o_video_valid),
    .i_video_ready   (i_video_ready),
    .o_video_sof     (o_video_sof),
    .o_video_eof     (o_video_eof),
    .o_dma_rd_index  (o_dma_rd_index),
    .o_dma_rd_done   (o_dma_rd_done),
    .o_overflow      (o_overflow),
    .o_len_err       (o_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) i_video_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (o_dma_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    ok = (o_dma_req === 1'b1);
    check("req_seen", DW'(o_dma_req), DW'(1'b1));
  endtask

  task automatic serve(input logic [AW-1:0] exp_addr, input int nwords);
    bit ok;
    wait_req(ok);
    if (ok) begin
      check("req_addr", DW'(o_dma_addr), DW'(exp_addr));
      check("req_len", DW'(o_dma_len), DW'(10'd16));
      tick();
      check("req_accepted", DW'(o_dma_req), DW'(1'b0));
      for (int w = 0; w < nwords; w++) begin
        i_dma_wr_data = {8{data_ctr}};
        i_dma_wr_en   = 1'b1;
        sb.push_back({8{data_ctr}});
        data_ctr = data_ctr + 32'd1;
        tick();
      end
      i_dma_wr_en   = 1'b0;
      i_dma_rx_done = 1'b1;
      tick();
      i_dma_rx_done = 1'b0;
    end
  endtask

  task automatic serve_frame(input logic [AW-1:0] base, input logic [1:0] idx);
    for (int r = 0; r < 4; r++) begin
      serve(base + AW'(r * 64), 2);
    end
    check("rd_done", DW'(o_dma_rd_done), DW'(1'b1));
    check("rd_index", DW'(o_dma_rd_index), DW'(idx));
    tick();
    check("rd_done_pulse", DW'(o_dma_rd_done), DW'(1'b0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (o_video_valid === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", DW'(o_video_valid), DW'(1'b0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, DW'(o_dma_req), DW'(1'b0));
    check({tag, "_addr"}, DW'(o_dma_addr), DW'(64'h0));
    check({tag, "_len"}, DW'(o_dma_len), DW'(10'd16));
    check({tag, "_valid"}, DW'(o_video_valid), DW'(1'b0));
    check({tag, "_data"}, o_video_data, {DW{1'b0}});
    check({tag, "_sof"}, DW'(o_video_sof), DW'(1'b0));
    check({tag, "_eof"}, DW'(o_video_eof), DW'(1'b0));
    check({tag, "_rd_done"}, DW'(o_dma_rd_done), DW'(1'b0));
    check({tag, "_rd_index"}, DW'(o_dma_rd_index), DW'(2'd0));
    check({tag, "_overflow"}, DW'(o_overflow), DW'(1'b0));
    check({tag, "_len_err"}, DW'(o_len_err), DW'(1'b0));
  endtask

  // Output stream monitor: order, sof on position 0, eof on position 7
  always @(negedge clk) begin
    if (!i_pcie_rst && o_video_valid === 1'b1 && i_video_ready === 1'b1) begin
      check("pop_expected", DW'(sb.size() != 0), DW'(1'b1));
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("pop_data", o_video_data, mon_exp);
      end
      check("pop_sof", DW'(o_video_sof), DW'(mon_idx == 0));
      check("pop_eof", DW'(o_video_eof), DW'(mon_idx == 7));
      mon_idx  = (mon_idx + 1) % 8;
      mon_pops = mon_pops + 1;
    end
  end

  initial begin
    bit ok;
    bit seen;
    int pops0;

    base0 = 64'h1000;
    base1 = 64'h2000;
    base2 = 64'h3000;
    base3 = 64'h4000;
    i_pcie_rst      = 1'b1;
    i_start_rx_flag = 1'b0;
    i_dma_cmd_rdy   = 1'b1;
    i_dma_wr_data   = '0;
    i_dma_wr_en     = 1'b0;
    i_dma_rx_done   = 1'b0;
    i_video_ready   = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    i_pcie_rst = 1'b0;
    tick();
    check("idle_no_req", DW'(o_dma_req), DW'(1'b0));

    // Four frames in a row, then the fifth restarts at buffer 0
    i_start_rx_flag = 1'b1;
    serve_frame(64'h1000, 2'd0);
    serve_frame(64'h2000, 2'd1);
    serve_frame(64'h3000, 2'd2);
    serve_frame(64'h4000, 2'd3);
    serve_frame(64'h1000, 2'd0);
    drain();

    // One frame with random consumer backpressure
    pops0 = mon_pops;
    rand_mode = 1'b1;
    serve_frame(64'h2000, 2'd1);
    drain();
    rand_mode = 1'b0;
    i_video_ready = 1'b1;
    check("frame_pops", DW'(mon_pops - pops0), DW'(8));

    // Consumer stalled: FIFO fills after four requests and fetching stops
    i_video_ready = 1'b0;
    serve_frame(64'h3000, 2'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_dma_req === 1'b1) seen = 1'b1;
    end
    check("no_5th_req", DW'(seen), DW'(1'b0));
    check("full_valid", DW'(o_video_valid), DW'(1'b1));
    i_video_ready = 1'b1;
    tick();
    tick();
    i_video_ready = 1'b0;
    serve(64'h4000, 2);
    check("no_overflow", DW'(o_overflow), DW'(1'b0));
    i_video_ready = 1'b1;

    // Short completion flags a length error and the FSM still advances
    serve(64'h4040, 1);
    check("len_err_set", DW'(o_len_err), DW'(1'b1));
    serve(64'h4080, 2);

    // Abort while a request is pending
    i_dma_cmd_rdy = 1'b0;
    wait_req(ok);
    check("pending_addr", DW'(o_dma_addr), DW'(64'h40C0));
    i_start_rx_flag = 1'b0;
    tick();
    sb.delete();
    mon_idx = 0;
    check("abort_req", DW'(o_dma_req), DW'(1'b0));
    check("abort_valid", DW'(o_video_valid), DW'(1'b0));
    check("abort_len_err", DW'(o_len_err), DW'(1'b1));
    i_dma_rx_done = 1'b1;
    tick();
    i_dma_rx_done = 1'b0;
    tick();
    check("idle_done_ignored_req", DW'(o_dma_req), DW'(1'b0));
    check("idle_done_len_err", DW'(o_len_err), DW'(1'b1));

    // Restart begins again at buffer 0
    i_dma_cmd_rdy   = 1'b1;
    i_start_rx_flag = 1'b1;
    serve_frame(64'h1000, 2'd0);
    serve(64'h2000, 2);
    serve(64'h2040, 2);

    // Asynchronous reset in the middle of the next request
    wait_req(ok);
    check("pre_rst_addr", DW'(o_dma_addr), DW'(64'h2080));
    #1;
    i_pcie_rst      = 1'b1;
    i_start_rx_flag = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    mon_idx = 0;
    tick();
    i_pcie_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_dma_req === 1'b1) seen = 1'b1;
    end
    check("no_req_before_start", DW'(seen), DW'(1'b0));
    i_start_rx_flag = 1'b1;
    serve(64'h1000, 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_rx_fun.md
PCIE_RX_FUN -- requirements
Module: pcie_rx_fun

Interface
REQ-001 Parameter: DMA_ADDR_WIDTH, 64, DMA address width.
REQ-002 Parameter: PCIE_DATA_WIDTH, 256, data word width in bits.
REQ-003 Parameter: DMA_LEN, 3840, bytes per DMA read request; a multiple of PCIE_DATA_WIDTH/8 and of 4. Derived: WPR = DMA_LEN*8/PCIE_DATA_WIDTH.
REQ-004 Parameter: FRAME_BYTES, 4147200, bytes per frame; a multiple of DMA_LEN. Derived: RPF = FRAME_BYTES/DMA_LEN and WPF = RPF*WPR.
REQ-005 Parameter: FIFO_DEPTH, 256, buffer depth in words; a power of 2 and at least WPR.
REQ-006 Ports:
- i_pcie_clk, in, 1: sole clock; i_pcie_rst, in, 1: asynchronous, active-high reset.
- i_dma_base_addr, i_dma_base_addr2, i_dma_base_addr3, i_dma_base_addr4, in, DMA_ADDR_WIDTH each: host frame buffers 0-3.
- i_start_rx_flag, in, 1: level; high = run, low = abort/idle.
- i_dma_cmd_rdy, in, 1: DMA engine accepts command.
- o_dma_req, out, 1: read request.
- o_dma_addr, out, DMA_ADDR_WIDTH: request address.
- o_dma_len, out, 10: request length in DW, constant DMA_LEN/4.
- i_dma_wr_data, in, PCIE_DATA_WIDTH: completion data; i_dma_wr_en, in, 1: data strobe.
- i_dma_rx_done, in, 1: pulse, current request complete.
- o_video_data, out, PCIE_DATA_WIDTH; o_video_valid, out, 1; i_video_ready, in, 1.
- o_video_sof, out, 1: first word of frame; o_video_eof, out, 1: last word of frame.
- o_dma_rd_index, out, 2: buffer index of last completed frame; o_dma_rd_done, out, 1: 1-cycle frame-fetched pulse.
- o_overflow, out, 1: sticky; o_len_err, out, 1: sticky.

Function
REQ-007 FSM states: IDLE, WAIT_SPACE, REQ, WAIT_DONE, FRAME_END.
REQ-008 IDLE: when i_start_rx_flag=1, load address from i_dma_base_addr, set index=0, go to WAIT_SPACE.
REQ-009 WAIT_SPACE: go to REQ when free FIFO entries >= WPR.
REQ-010 REQ: o_dma_req=1; a command is accepted in a cycle with o_dma_req & i_dma_cmd_rdy; on acceptance go to WAIT_DONE. o_dma_addr is stable while o_dma_req=1.
REQ-011 WAIT_DONE: count i_dma_wr_en words. On i_dma_rx_done:
- if word count != WPR, set o_len_err;
- clear word count;
- if request count = RPF-1, go to FRAME_END;
- else add DMA_LEN to address and go to WAIT_SPACE.
REQ-012 FRAME_END (1 cycle):
- o_dma_rd_done=1 and o_dma_rd_index=current index;
- index increments mod 4;
- address loads the base address of the new index (0 -> base, 1 -> base2, 2 -> base3, 3 -> base4);
- request count clears; go to WAIT_SPACE.
REQ-013 Exactly one request is outstanding at a time.
REQ-014 FIFO: words are written on i_dma_wr_en. A write when full is dropped and sets o_overflow; this cannot occur while REQ-009 holds.
REQ-015 FIFO read is first-word fall-through: o_video_valid = !empty, and a word pops on o_video_valid & i_video_ready. o_video_data is stable while valid & !ready. Simultaneous read and write when full or empty is legal and loses no data.
REQ-016 Output word counter runs 0..WPF-1 and wraps:
- o_video_sof = valid & (count = 0);
- o_video_eof = valid & (count = WPF-1).
REQ-017 i_start_rx_flag low in any state: next cycle go to IDLE, and clear the FIFO, all counters, index and o_dma_req. Sticky flags hold. An i_dma_rx_done arriving in IDLE is ignored.
REQ-018 Address arithmetic is modulo 2^DMA_ADDR_WIDTH. No latency target beyond a 1-cycle state transition per event.

Reset
REQ-019 Reset values: all outputs 0 except o_dma_len; FSM = IDLE; FIFO empty; counters, index and address 0; sticky flags cleared. o_dma_len is constant DMA_LEN/4.
REQ-020 Reset is asserted asynchronously. Deassertion is synchronous to i_pcie_clk, and only reset clears the sticky flags.

Verification (DMA_LEN=64, FRAME_BYTES=256, FIFO_DEPTH=8 -> WPR=2, RPF=4, WPF=8; bases 0x1000, 0x2000, 0x3000, 0x4000)
REQ-021 Start with i_video_ready=1 and cmd_rdy=1:
- requests at 0x1000, 0x1040, 0x1080, 0x10C0;
- o_dma_len=16 on every request;
- o_dma_rd_done pulses with index 0;
- the next request is at 0x2000.
REQ-022 Four frames in a row: o_dma_rd_index goes 0, 1, 2, 3, and the fifth frame's first address is 0x1000.
REQ-023 Hold i_video_ready=0: after 4 requests (8 words) no 5th request is issued. Raise ready for 2 pops -> the 5th request is issued. o_overflow stays 0.
REQ-024 Stream a frame with random ready: exactly 8 pops; sof on pop 0 only; eof on pop 7 only; data order matches the completion order.
REQ-025 Send i_dma_rx_done after 1 word -> o_len_err=1 and the FSM advances. Drop i_start_rx_flag mid-request -> IDLE, o_video_valid=0, o_dma_req=0, o_len_err still 1. Restart -> the first request is at 0x1000.
REQ-026 Assert i_pcie_rst mid-frame, then release -> all outputs at reset values in the same cycle (asynchronous), and no request is issued until i_start_rx_flag=1.
